// File: rtl/gelu_pkg.sv
// gelu_pkg: shared Q5.26 constants and antilog pipeline stage types
package gelu_pkg;
  localparam int Q = 26;
  localparam int W = 32;
  localparam int KW = W - Q;
  localparam logic [W-1:0] ONE_Q = 32'h04000000;
  localparam logic [W-1:0] SAT_POS = 32'h7FFFFFFF;
  localparam logic [W-1:0] SAT_NEG = 32'h80000001;
  localparam logic signed [KW-1:0] K_SAT = KW'(W - Q - 1);
  typedef struct packed {
    logic v;
    logic sign;
    logic signed [KW-1:0] k;
    logic [Q-1:0] f;
  } s1_t;
  typedef struct packed {
    logic v;
    logic sign;
    logic sat;
    logic [W-1:0] mag;
  } s2_t;
endpackage

// File: rtl/du_pow2_shift.sv
// du_pow2_shift: mantissa scaled by 2^k with saturation flag; DU_ANTILOG_ROUND_EN rounds right shifts half-up
module du_pow2_shift
  import gelu_pkg::*;
(
  input  logic [Q:0]             m,
  input  logic signed [KW-1:0]   k,
  output logic [W-1:0]           mag,
  output logic                   sat
);
  logic [KW:0] s;
  logic [W-1:0] rs;
  assign sat = k >= K_SAT;
  assign s = -{k[KW-1], k};
`ifdef DU_ANTILOG_ROUND_EN
  assign rs = W'(((W+1)'(m) + ((W+1)'(1) << (s - (KW+1)'(1)))) >> s);
`else
  assign rs = W'((W+1)'(m) >> s);
`endif
  // saturated lanes carry zero; the output stage substitutes the clamp value
  assign mag = sat ? '0 : k[KW-1] ? rs : W'(m) << k;
endmodule

// File: rtl/du_antilog.sv
// du_antilog: 3-stage Mitchell antilog (log2 Q5.26 -> signed linear Q5.26); DU_ANTILOG_ROUND_EN selects rounding
module du_antilog
  import gelu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         in_ready,
  input  logic [W-1:0] exponent,
  input  logic         result_sign,
  output logic         valid_out,
  input  logic         out_ready,
  output logic [W-1:0] result
);
  s1_t s1;
  s2_t s2;
  logic en, sat;
  logic [W-1:0] mag, mag3;
  assign en = out_ready | ~valid_out;
  assign in_ready = en;
  du_pow2_shift u_shift (
    .m({1'b1, s1.f}),
    .k(s1.k),
    .mag(mag),
    .sat(sat)
  );
  assign mag3 = s2.sat ? SAT_POS : s2.mag;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      valid_out <= 1'b0;
      result <= '0;
    end else if (en) begin
      s1 <= {valid_in, result_sign, exponent};
      s2 <= {s1.v, s1.sign, sat, mag};
      valid_out <= s2.v;
      result <= s2.sign ? -mag3 : mag3;
    end
endmodule

// File: tb/tb_du_antilog.sv
// tb_du_antilog: directed checks of du_antilog values, saturation, rounding, backpressure and reset
module tb_du_antilog;
  logic clk = 0, rst = 1, valid_in = 0, result_sign = 0, out_ready = 1;
  logic in_ready, valid_out;
  logic [31:0] exponent = '0, result;
  int ntot = 0, nfail = 0;

  du_antilog dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
    .exponent(exponent), .result_sign(result_sign), .valid_out(valid_out),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntot++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic run1(input string tag, input logic [31:0] e, input logic sg, input logic [31:0] want);
    @(negedge clk);
    out_ready = 1; exponent = e; result_sign = sg; valid_in = 1;
    #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    valid_in = 0;
    chk({tag, "_lat1"}, 32'(valid_out), 32'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(valid_out), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(valid_out), 32'd1);
    chk(tag, result, want);
  endtask

  logic [31:0] bp_in [5] = '{32'h00000000, 32'h04000000, 32'hFC000000, 32'h02000000, 32'h10000000};
  logic [31:0] bp_exp [5] = '{32'h04000000, 32'h08000000, 32'h02000000, 32'h06000000, 32'h40000000};
  logic [31:0] rnd_exp;
  logic [31:0] held;
  int idx, nout, stall;
  bit started;

  initial begin
`ifdef DU_ANTILOG_ROUND_EN
    rnd_exp = 32'h00000001;
`else
    rnd_exp = 32'h00000000;
`endif
    repeat (2) @(negedge clk);
    out_ready = 0;
    #1;
    chk("rst_vout", 32'(valid_out), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst = 0;
    run1("one", 32'h00000000, 0, 32'h04000000);
    run1("two", 32'h04000000, 0, 32'h08000000);
    run1("half", 32'hFC000000, 0, 32'h02000000);
    run1("mitchell", 32'h02000000, 0, 32'h06000000);
    run1("neg_two", 32'h04000000, 1, 32'hF8000000);
    run1("sat_pos", 32'h14000000, 0, 32'h7FFFFFFF);
    run1("sat_neg", 32'h14000000, 1, 32'h80000001);
    run1("k4", 32'h10000000, 0, 32'h40000000);
    run1("under27", 32'h94000000, 0, rnd_exp);
    run1("under32", 32'h80000000, 0, 32'h00000000);
    run1("under32_neg", 32'h80000000, 1, 32'h00000000);
    idx = 0; nout = 0; stall = 0; started = 0; held = '0;
    for (int c = 0; c < 40 && nout < 5; c++) begin
      @(negedge clk);
      if (valid_out && !started) begin
        started = 1;
        stall = 4;
        held = result;
      end
      out_ready = (stall == 0);
      valid_in = idx < 5;
      exponent = idx < 5 ? bp_in[idx] : '0;
      result_sign = 0;
      #1;
      if (stall > 0) begin
        chk("stall_rdy", 32'(in_ready), 32'd0);
        chk("stall_vout", 32'(valid_out), 32'd1);
        chk("stall_res", result, held);
        stall--;
      end
      if (valid_in && in_ready) idx++;
      if (valid_out && out_ready) begin
        chk("bp_res", result, bp_exp[nout]);
        nout++;
      end
    end
    chk("bp_count", 32'(nout), 32'd5);
    chk("bp_stall_seen", 32'(started), 32'd1);
    valid_in = 0;
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("bp_nodup", 32'(valid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1; exponent = bp_in[i]; out_ready = 1;
    end
    @(negedge clk);
    valid_in = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mrst_vout", 32'(valid_out), 32'd0);
    chk("mrst_res", result, 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_stale", 32'(valid_out), 32'd0);
    end
    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end
endmodule
